cpu_trace_fifo: RTL and testbench

CPU_TRACE_FIFO -- requirements
Module: cpu_trace_fifo

---
 rtl/cpu_trace_fifo.sv | 127 ++++++++++++
 tb/tb_cpu_trace_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_fifo.sv
// cpu_trace_fifo: captures each change of the CPU a0 register into a show-ahead FIFO.
// A capture happens when en_i is high and a0_i differs from the last captured value.
// Optional feature: define TRACE_PC_EN to store pc_i with each entry and expose pc_o.
module cpu_trace_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       flush_i,
    input  logic [DW-1:0]              a0_i,
    input  logic [DW-1:0]              pc_i,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [DW-1:0]              data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
`ifdef TRACE_PC_EN
    ,
    output logic [DW-1:0]              pc_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] last_q, last_d;

    logic [DW-1:0] data_mem_q [DEPTH];
`ifdef TRACE_PC_EN
    logic [DW-1:0] pc_mem_q [DEPTH];
`else
    logic          unused_pc;
    assign unused_pc = ^pc_i;
`endif

    logic capture;
    logic full;
    logic valid;
    logic pop;
    logic push;
    logic drop;
    logic wr_en;

    // Event decode and next-state computation; flush wins over push/pop but not over last_q.
    always_comb begin
        valid   = (count_q != '0);
        full    = (count_q == CW'(DEPTH));
        capture = en_i && (a0_i != last_q);
        pop     = valid && ready_i;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        last_d     = capture ? a0_i : last_q;
        wr_en      = 1'b0;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            wr_en = push;
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            overflow_d = overflow_q | drop;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    // Entry storage; contents are qualified by count_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem_q[wr_ptr_q] <= a0_i;
`ifdef TRACE_PC_EN
            pc_mem_q[wr_ptr_q]   <= pc_i;
`endif
        end
    end

    // Show-ahead head outputs, forced to zero while empty.
    always_comb begin
        valid_o    = valid;
        count_o    = count_q;
        overflow_o = overflow_q;
        data_o     = valid ? data_mem_q[rd_ptr_q] : '0;
`ifdef TRACE_PC_EN
        pc_o       = valid ? pc_mem_q[rd_ptr_q] : '0;
`endif
    end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Self-checking bench for cpu_trace_fifo (DW=32, DEPTH=16) against a queue-based model.
// Define TRACE_PC_EN to also check pc_o.
module tb_cpu_trace_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          en_i;
    logic          flush_i;
    logic [DW-1:0] a0_i;
    logic [DW-1:0] pc_i;
    logic          ready_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [4:0]    count_o;
    logic          overflow_o;
`ifdef TRACE_PC_EN
    logic [DW-1:0] pc_o;
`endif

    cpu_trace_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .flush_i    (flush_i),
        .a0_i       (a0_i),
        .pc_i       (pc_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
`ifdef TRACE_PC_EN
        ,
        .pc_o       (pc_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] mq_data [$];
    logic [DW-1:0] mq_pc [$];
    logic [DW-1:0] m_last;
    logic          m_ovf;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        mq_data.delete();
        mq_pc.delete();
        m_last = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [DW-1:0] a0, input logic [DW-1:0] pc,
                              input logic fl, input logic rdy);
        bit cap;
        bit pop;
        cap = en && (a0 != m_last);
        pop = (mq_data.size() != 0) && rdy;
        if (cap) m_last = a0;
        if (fl) begin
            mq_data.delete();
            mq_pc.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) begin
                void'(mq_data.pop_front());
                void'(mq_pc.pop_front());
            end
            if (cap) begin
                if (mq_data.size() < DEPTH) begin
                    mq_data.push_back(a0);
                    mq_pc.push_back(pc);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [4:0]    e_count;
        e_valid = (mq_data.size() != 0);
        e_data  = e_valid ? mq_data[0] : '0;
        e_count = 5'(mq_data.size());
        checks++;
        assert (valid_o === e_valid) else begin
            errors++;
            $error("FAIL %s valid_o got %0b want %0b", tag, valid_o, e_valid);
        end
        checks++;
        assert (data_o === e_data) else begin
            errors++;
            $error("FAIL %s data_o got %h want %h", tag, data_o, e_data);
        end
        checks++;
        assert (count_o === e_count) else begin
            errors++;
            $error("FAIL %s count_o got %0d want %0d", tag, count_o, e_count);
        end
        checks++;
        assert (overflow_o === m_ovf) else begin
            errors++;
            $error("FAIL %s overflow_o got %0b want %0b", tag, overflow_o, m_ovf);
        end
`ifdef TRACE_PC_EN
        begin
            logic [DW-1:0] e_pc;
            e_pc = e_valid ? mq_pc[0] : '0;
            checks++;
            assert (pc_o === e_pc) else begin
                errors++;
                $error("FAIL %s pc_o got %h want %h", tag, pc_o, e_pc);
            end
        end
`endif
    endtask

    // Apply inputs for one cycle, advance the model across the edge, then check #1 after it.
    task automatic step(input string tag, input logic en, input logic [DW-1:0] a0,
                        input logic [DW-1:0] pc, input logic fl, input logic rdy);
        en_i    = en;
        a0_i    = a0;
        pc_i    = pc;
        flush_i = fl;
        ready_i = rdy;
        model_edge(en, a0, pc, fl, rdy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic check_const(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    initial begin
        rst     = 1'b0;
        en_i    = 1'b0;
        flush_i = 1'b0;
        a0_i    = '0;
        pc_i    = '0;
        ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Capture after reset: a0 is 0 for two cycles (equals last_q), then 5.
        step("cap0_a", 1'b1, 32'd0, 32'h0, 1'b0, 1'b0);
        step("cap0_b", 1'b1, 32'd0, 32'h0, 1'b0, 1'b0);
        step("cap5", 1'b1, 32'd5, 32'h4, 1'b0, 1'b0);
        check_const("cap5_count", int'(count_o), 1);
        check_const("cap5_data", int'(data_o), 5);

        // Held value produces no duplicates.
        for (int i = 0; i < 10; i++) step("hold5", 1'b1, 32'd5, 32'h8, 1'b0, 1'b0);
        step("cap7", 1'b1, 32'd7, 32'hc, 1'b0, 1'b0);
        check_const("nodup_count", int'(count_o), 2);
        step("drain_a", 1'b0, 32'd7, 32'h0, 1'b0, 1'b1);
        step("drain_b", 1'b0, 32'd7, 32'h0, 1'b0, 1'b1);
        step("pop_empty", 1'b0, 32'd7, 32'h0, 1'b0, 1'b1);

        // Flush with three entries; capture on the flush edge is dropped but updates last.
        for (int i = 0; i < 3; i++) step("fill3", 1'b1, 32'(20 + i), 32'(i), 1'b0, 1'b0);
        step("flush", 1'b1, 32'd30, 32'h0, 1'b1, 1'b1);
        step("post_flush_dup", 1'b1, 32'd30, 32'h0, 1'b0, 1'b0);
        step("flush_empty", 1'b0, 32'd30, 32'h0, 1'b1, 1'b0);

        // Overflow: 17 distinct values into a 16-deep FIFO, then drain in order.
        for (int i = 0; i < 17; i++) step("ovf_fill", 1'b1, 32'(100 + i), 32'(i * 4), 1'b0, 1'b0);
        check_const("ovf_count", int'(count_o), 16);
        check_const("ovf_flag", int'(overflow_o), 1);
        for (int i = 0; i < 16; i++) begin
            check_const("ovf_drain_order", int'(data_o), 100 + i);
            step("ovf_drain", 1'b0, 32'd0, 32'h0, 1'b0, 1'b1);
        end
        check_const("ovf_sticky", int'(overflow_o), 1);
        step("ovf_clear", 1'b0, 32'd0, 32'h0, 1'b1, 1'b0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) step("full_fill", 1'b1, 32'(200 + i), 32'(i), 1'b0, 1'b0);
        step("full_pushpop", 1'b1, 32'hAB, 32'h40, 1'b0, 1'b1);
        check_const("fpp_count", int'(count_o), 16);
        check_const("fpp_ovf", int'(overflow_o), 0);
        for (int i = 0; i < 16; i++) step("fpp_drain", 1'b0, 32'hAB, 32'h0, 1'b0, 1'b1);

`ifdef TRACE_PC_EN
        step("pc_cap", 1'b1, 32'd9, 32'h0000_0010, 1'b0, 1'b0);
        check_const("pc_head", int'(pc_o), 16);
        check_const("pc_data", int'(data_o), 9);
`endif

        // Asynchronous reset in the middle of a cycle with entries present.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 32'(300 + i), 32'(i), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("rst_zero_nocap", 1'b1, 32'd0, 32'h0, 1'b0, 1'b0);
        step("rst_first_cap", 1'b1, 32'd3, 32'h0, 1'b0, 1'b0);

        // Randomized traffic; small value range gives frequent repeats and full/empty hits.
        for (int i = 0; i < 800; i++) begin
            logic en, fl, rdy;
            en  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 79) == 0);
            rdy = (i % 200 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            step("rand", en, 32'($urandom_range(0, 7)), $urandom, fl, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
